// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the PainterEngine GPU DMA reader and writer:
// FSM encodings, error codes and the fixed AXI attribute values.
package painterengine_gpu_dma_pkg;

  typedef enum logic [2:0] {
    ROUTING       = 3'd0,
    PARAM_CHECK   = 3'd1,
    CALC_ADDRESS  = 3'd2,
    ADDRESS_WRITE = 3'd3,
    DATA_WRITE    = 3'd4,
    RESPONSE      = 3'd5,
    DONE          = 3'd6,
    ERROR         = 3'd7
  } dma_state_t;

  localparam logic [2:0] ERR_NONE       = 3'b000;
  localparam logic [2:0] ERR_ROUTER     = 3'b001;
  localparam logic [2:0] ERR_PARAM      = 3'b010;
  localparam logic [2:0] ERR_AW_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_W_TIMEOUT  = 3'b100;
  localparam logic [2:0] ERR_BRESP      = 3'b101;
  localparam logic [2:0] ERR_B_TIMEOUT  = 3'b110;

  localparam logic       AXI_ID    = 1'b0;
  localparam logic [2:0] AXI_SIZE  = 3'b010;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic       AXI_LOCK  = 1'b0;
  localparam logic [3:0] AXI_CACHE = 4'b0010;
  localparam logic [2:0] AXI_PROT  = 3'b000;
  localparam logic [3:0] AXI_QOS   = 4'b0000;
  localparam logic [3:0] AXI_WSTRB = 4'hF;

endpackage

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 burst writer: streams words from one of four sources to memory,
// splitting the transfer into INCR bursts that never cross a 1 KiB page.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int TIMEOUT_BIT = 18
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  input  logic [127:0] i_wire_data,
  input  logic [3:0]   i_wire_data_valid,
  output logic [3:0]   o_wire_data_next,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_AWID,
  output logic [31:0]  o_wire_M_AXI_AWADDR,
  output logic [7:0]   o_wire_M_AXI_AWLEN,
  output logic [2:0]   o_wire_M_AXI_AWSIZE,
  output logic [1:0]   o_wire_M_AXI_AWBURST,
  output logic         o_wire_M_AXI_AWLOCK,
  output logic [3:0]   o_wire_M_AXI_AWCACHE,
  output logic [2:0]   o_wire_M_AXI_AWPROT,
  output logic [3:0]   o_wire_M_AXI_AWQOS,
  output logic         o_wire_M_AXI_AWVALID,
  input  logic         i_wire_M_AXI_AWREADY,
  output logic [31:0]  o_wire_M_AXI_WDATA,
  output logic [3:0]   o_wire_M_AXI_WSTRB,
  output logic         o_wire_M_AXI_WLAST,
  output logic         o_wire_M_AXI_WVALID,
  input  logic         i_wire_M_AXI_WREADY,
  input  logic         i_wire_M_AXI_BID,
  input  logic [1:0]   i_wire_M_AXI_BRESP,
  input  logic         i_wire_M_AXI_BVALID,
  output logic         o_wire_M_AXI_BREADY
);

  dma_state_t             state, state_next;
  logic [31:0]            address_q, address_next;
  logic [31:0]            length_q, length_next;
  logic [31:0]            offset_q, offset_next;
  logic [1:0]             index_q, index_next;
  logic [8:0]             burstlen_q, burstlen_next;
  logic [8:0]             beat_q, beat_next;
  logic [31:0]            awaddr_q, awaddr_next;
  logic [7:0]             awlen_q, awlen_next;
  logic [2:0]             error_type_q, error_type_next;
  logic [TIMEOUT_BIT:0]   timeout_q, timeout_next;

  logic [31:0]            lane_data;
  logic                   lane_valid;
  logic [31:0]            remaining;
  logic [7:0]             page_word;
  logic [8:0]             aligned;
  logic [8:0]             burst_len;
  logic [8:0]             burst_len_m1;
  logic [8:0]             last_beat;
  logic [31:0]            offset_sum;
  logic                   handshake;
  logic                   stall_state;
  logic                   route_ok;
  logic [1:0]             route_idx;
  logic                   unused_bid;

  assign unused_bid = i_wire_M_AXI_BID;

  assign lane_data  = i_wire_data[{index_q, 5'b00000} +: 32];
  assign lane_valid = i_wire_data_valid[index_q];

  // Words left in the 1 KiB page bound the burst, along with the words left overall.
  assign remaining    = length_q - offset_q;
  assign page_word    = address_q[9:2] + offset_q[7:0];
  assign aligned      = 9'd256 - {1'b0, page_word};
  assign burst_len    = (remaining < {23'd0, aligned}) ? remaining[8:0] : aligned;
  assign burst_len_m1 = burst_len - 9'd1;
  assign last_beat    = burstlen_q - 9'd1;
  assign offset_sum   = offset_q + {23'd0, burstlen_q};

  always_comb begin
    route_ok  = 1'b1;
    route_idx = 2'd0;
    case (i_wire_router)
      4'b0001: route_idx = 2'd0;
      4'b0010: route_idx = 2'd1;
      4'b0100: route_idx = 2'd2;
      4'b1000: route_idx = 2'd3;
      default: route_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = state;
    address_next    = address_q;
    length_next     = length_q;
    offset_next     = offset_q;
    index_next      = index_q;
    burstlen_next   = burstlen_q;
    beat_next       = beat_q;
    awaddr_next     = awaddr_q;
    awlen_next      = awlen_q;
    error_type_next = error_type_q;
    handshake       = 1'b0;
    stall_state     = 1'b0;

    case (state)
      ROUTING: begin
        if (route_ok) begin
          index_next   = route_idx;
          address_next = i_wire_address[{route_idx, 5'b00000} +: 32];
          length_next  = i_wire_length[{route_idx, 5'b00000} +: 32];
          state_next   = PARAM_CHECK;
        end else begin
          error_type_next = ERR_ROUTER;
          state_next      = ERROR;
        end
      end
      PARAM_CHECK: begin
        if (address_q[1:0] != 2'b00 || length_q == 32'd0) begin
          error_type_next = ERR_PARAM;
          state_next      = ERROR;
        end else begin
          offset_next = 32'd0;
          state_next  = CALC_ADDRESS;
        end
      end
      CALC_ADDRESS: begin
        burstlen_next = burst_len;
        awlen_next    = burst_len_m1[7:0];
        awaddr_next   = address_q + {offset_q[29:0], 2'b00};
        state_next    = ADDRESS_WRITE;
      end
      ADDRESS_WRITE: begin
        stall_state = 1'b1;
        handshake   = i_wire_M_AXI_AWREADY;
        if (handshake) begin
          beat_next  = 9'd0;
          state_next = DATA_WRITE;
        end
      end
      DATA_WRITE: begin
        stall_state = 1'b1;
        handshake   = lane_valid && i_wire_M_AXI_WREADY;
        if (handshake) begin
          beat_next = beat_q + 9'd1;
          if (beat_q == last_beat) state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        stall_state = 1'b1;
        handshake   = i_wire_M_AXI_BVALID;
        if (handshake) begin
          if (i_wire_M_AXI_BRESP != 2'b00) begin
            error_type_next = ERR_BRESP;
            state_next      = ERROR;
          end else begin
            offset_next = offset_sum;
            state_next  = (offset_sum >= length_q) ? DONE : CALC_ADDRESS;
          end
        end
      end
      DONE:  state_next = DONE;
      ERROR: state_next = ERROR;
    endcase

    // A stuck handshake wins over whatever the bus did this cycle.
    if (stall_state && timeout_q[TIMEOUT_BIT]) begin
      state_next = ERROR;
      case (state)
        ADDRESS_WRITE: error_type_next = ERR_AW_TIMEOUT;
        DATA_WRITE:    error_type_next = ERR_W_TIMEOUT;
        default:       error_type_next = ERR_B_TIMEOUT;
      endcase
    end

    if (stall_state && !handshake && state_next == state)
      timeout_next = timeout_q + {{TIMEOUT_BIT{1'b0}}, 1'b1};
    else
      timeout_next = '0;
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state        <= ROUTING;
      address_q    <= 32'd0;
      length_q     <= 32'd0;
      offset_q     <= 32'd0;
      index_q      <= 2'd0;
      burstlen_q   <= 9'd0;
      beat_q       <= 9'd0;
      awaddr_q     <= 32'd0;
      awlen_q      <= 8'd0;
      error_type_q <= ERR_NONE;
      timeout_q    <= '0;
    end else begin
      state        <= state_next;
      address_q    <= address_next;
      length_q     <= length_next;
      offset_q     <= offset_next;
      index_q      <= index_next;
      burstlen_q   <= burstlen_next;
      beat_q       <= beat_next;
      awaddr_q     <= awaddr_next;
      awlen_q      <= awlen_next;
      error_type_q <= error_type_next;
      timeout_q    <= timeout_next;
    end
  end

  assign o_wire_done       = (state == DONE);
  assign o_wire_error      = (state == ERROR);
  assign o_wire_error_type = error_type_q;

  assign o_wire_M_AXI_AWID    = AXI_ID;
  assign o_wire_M_AXI_AWSIZE  = AXI_SIZE;
  assign o_wire_M_AXI_AWBURST = AXI_BURST;
  assign o_wire_M_AXI_AWLOCK  = AXI_LOCK;
  assign o_wire_M_AXI_AWCACHE = AXI_CACHE;
  assign o_wire_M_AXI_AWPROT  = AXI_PROT;
  assign o_wire_M_AXI_AWQOS   = AXI_QOS;
  assign o_wire_M_AXI_WSTRB   = AXI_WSTRB;

  assign o_wire_M_AXI_AWADDR  = awaddr_q;
  assign o_wire_M_AXI_AWLEN   = awlen_q;
  assign o_wire_M_AXI_AWVALID = (state == ADDRESS_WRITE);
  assign o_wire_M_AXI_WVALID  = (state == DATA_WRITE) && lane_valid;
  assign o_wire_M_AXI_WDATA   = (state == DATA_WRITE) ? lane_data : 32'd0;
  assign o_wire_M_AXI_WLAST   = (state == DATA_WRITE) && (beat_q == last_beat);
  assign o_wire_M_AXI_BREADY  = (state == RESPONSE);
  assign o_wire_data_next     = (state == DATA_WRITE) ?
                                ({3'b000, i_wire_M_AXI_WREADY} << index_q) : 4'b0000;

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Randomized self-checking bench for the DMA writer; a transaction-level
// model predicts the burst split, beat data and completion status.
module tb_painterengine_gpu_dma_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   router = 4'b0000;
  logic [127:0] address = '0;
  logic [127:0] length = '0;
  logic [127:0] data = '0;
  logic [3:0]   dvalid = 4'b0000;
  logic [3:0]   dataNext;
  logic         done, error;
  logic [2:0]   errorType;
  logic         awId, awLock, awValid, awReady = 1'b0;
  logic [31:0]  awAddr;
  logic [7:0]   awLen;
  logic [2:0]   awSize, awProt;
  logic [1:0]   awBurst;
  logic [3:0]   awCache, awQos;
  logic [31:0]  wData;
  logic [3:0]   wStrb;
  logic         wLast, wValid, wReady = 1'b0;
  logic         bId = 1'b0;
  logic [1:0]   bResp = 2'b00;
  logic         bValid = 1'b0;
  logic         bReady;

  int testsRun = 0;
  int failCount = 0;

  logic [31:0] awAddrQ[$];
  logic [7:0]  awLenQ[$];
  logic [31:0] srcWords[$];

  painterengine_gpu_dma_writer #(.TIMEOUT_BIT(6)) dut (
    .i_wire_clock(clk),
    .i_wire_reset(rst),
    .i_wire_router(router),
    .i_wire_address(address),
    .i_wire_length(length),
    .i_wire_data(data),
    .i_wire_data_valid(dvalid),
    .o_wire_data_next(dataNext),
    .o_wire_done(done),
    .o_wire_error(error),
    .o_wire_error_type(errorType),
    .o_wire_M_AXI_AWID(awId),
    .o_wire_M_AXI_AWADDR(awAddr),
    .o_wire_M_AXI_AWLEN(awLen),
    .o_wire_M_AXI_AWSIZE(awSize),
    .o_wire_M_AXI_AWBURST(awBurst),
    .o_wire_M_AXI_AWLOCK(awLock),
    .o_wire_M_AXI_AWCACHE(awCache),
    .o_wire_M_AXI_AWPROT(awProt),
    .o_wire_M_AXI_AWQOS(awQos),
    .o_wire_M_AXI_AWVALID(awValid),
    .i_wire_M_AXI_AWREADY(awReady),
    .o_wire_M_AXI_WDATA(wData),
    .o_wire_M_AXI_WSTRB(wStrb),
    .o_wire_M_AXI_WLAST(wLast),
    .o_wire_M_AXI_WVALID(wValid),
    .i_wire_M_AXI_WREADY(wReady),
    .i_wire_M_AXI_BID(bId),
    .i_wire_M_AXI_BRESP(bResp),
    .i_wire_M_AXI_BVALID(bValid),
    .o_wire_M_AXI_BREADY(bReady)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Split a transfer into page-bounded bursts of at most 256 words.
  function automatic void buildBursts(input logic [31:0] addr, input int len);
    int off = 0;
    awAddrQ.delete();
    awLenQ.delete();
    while (off < len) begin
      int word = ((int'(addr >> 2)) + off) % 256;
      int room = 256 - word;
      int b    = (room < len - off) ? room : len - off;
      awAddrQ.push_back(addr + 32'(off * 4));
      awLenQ.push_back(8'(b - 1));
      off += b;
    end
  endfunction

  task automatic resetDut(input logic [3:0] rtr);
    @(negedge clk);
    rst = 1'b1; router = rtr; awReady = 1'b0; wReady = 1'b0;
    bValid = 1'b0; bResp = 2'b00; dvalid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkIdleBus(input string name);
    checkOutput({name, "_awvalid"}, awValid, 0);
    checkOutput({name, "_wvalid"}, wValid, 0);
    checkOutput({name, "_bready"}, bReady, 0);
    checkOutput({name, "_data_next"}, dataNext, 0);
  endtask

  // One full transfer from a slot; stopAt>0 abandons it silently after that many cycles.
  task automatic applyStimulus(input int slot, input logic [31:0] addr, input int len,
                               input logic [1:0] respCode, input int gapPct, input int stopAt);
    int phase = 0, curLen = 0, beat = 0, srcPtr = 0, awSeen = 0, expAw;
    bit bPending = 0;
    logic [3:0] dv;
    buildBursts(addr, len);
    expAw = awAddrQ.size();
    srcWords.delete();
    for (int i = 0; i < len; i++) srcWords.push_back($urandom);
    for (int k = 0; k < 4; k++) begin
      address[k*32 +: 32] = (k == slot) ? addr : $urandom;
      length[k*32 +: 32]  = (k == slot) ? 32'(len) : $urandom;
    end
    resetDut(4'b0001 << slot);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (stopAt > 0 && cyc == stopAt) return;
      @(negedge clk);
      awReady = ($urandom_range(99) >= gapPct);
      wReady  = ($urandom_range(99) >= gapPct);
      dv      = 4'($urandom);
      dv[slot] = ($urandom_range(99) >= gapPct) && (srcPtr < len);
      dvalid  = dv;
      data    = {$urandom, $urandom, $urandom, $urandom};
      if (srcPtr < len) data[slot*32 +: 32] = srcWords[srcPtr];
      bValid  = bPending && ($urandom_range(99) >= gapPct);
      bResp   = respCode;
      #1;
      if (phase == 3) begin
        checkOutput("done", done, 1);
        checkOutput("done_error", error, 0);
        checkOutput("done_type", errorType, 0);
        checkOutput("aw_count", awSeen, expAw);
        checkOutput("beats", srcPtr, len);
        checkOutput("done_awvalid", awValid, 0);
        checkOutput("done_wvalid", wValid, 0);
        checkOutput("done_bready", bReady, 0);
        return;
      end
      if (phase == 4) begin
        checkOutput("bresp_error", error, 1);
        checkOutput("bresp_type", errorType, 3'b101);
        checkOutput("bresp_done", done, 0);
        checkIdleBus("bresp");
        return;
      end
      checkOutput("busy_done", done, 0);
      checkOutput("busy_error", error, 0);
      case (phase)
        0: begin
          checkOutput("addr_wvalid", wValid, 0);
          checkOutput("addr_bready", bReady, 0);
          checkOutput("addr_data_next", dataNext, 0);
          if (awValid && awAddrQ.size() > 0) begin
            checkOutput("awaddr", awAddr, awAddrQ[0]);
            checkOutput("awlen", awLen, awLenQ[0]);
          end
        end
        1: begin
          checkOutput("data_awvalid", awValid, 0);
          checkOutput("data_bready", bReady, 0);
          checkOutput("wvalid", wValid, dv[slot]);
          checkOutput("data_next", dataNext, 4'(wReady) << slot);
          if (dv[slot]) begin
            checkOutput("wdata", wData, srcWords[srcPtr]);
            checkOutput("wlast", wLast, beat == curLen - 1);
          end
        end
        default: begin
          checkOutput("resp_awvalid", awValid, 0);
          checkOutput("resp_wvalid", wValid, 0);
          checkOutput("resp_data_next", dataNext, 0);
          checkOutput("bready", bReady, 1);
        end
      endcase
      if (phase == 0 && awValid && awReady && awAddrQ.size() > 0) begin
        curLen = int'(awLenQ[0]) + 1;
        void'(awAddrQ.pop_front());
        void'(awLenQ.pop_front());
        awSeen++;
        beat  = 0;
        phase = 1;
      end else if (phase == 1 && dv[slot] && wReady) begin
        srcPtr++;
        beat++;
        if (beat == curLen) begin
          phase    = 2;
          bPending = 1;
        end
      end else if (phase == 2 && bValid) begin
        bPending = 0;
        if (respCode != 2'b00) phase = 4;
        else phase = (awAddrQ.size() == 0) ? 3 : 0;
      end
    end
    checkOutput("transfer_cycle_budget", 0, 1);
  endtask

  // Drive a transfer that must end in ERROR; mode 1/2/3 stalls AW/W/B forever.
  task automatic runError(input logic [3:0] rtr, input logic [31:0] addr, input logic [31:0] len,
                          input int mode, input logic [2:0] expType, input string name);
    address = {4{addr}};
    length  = {4{len}};
    resetDut(rtr);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      awReady = (mode != 1);
      wReady  = (mode != 2);
      bValid  = 1'b0;
      dvalid  = 4'hF;
      data    = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (error || done) break;
    end
    checkOutput({name, "_error"}, error, 1);
    checkOutput({name, "_type"}, errorType, expType);
    checkOutput({name, "_done"}, done, 0);
    checkIdleBus(name);
    router = 4'b0001;
    repeat (3) @(negedge clk);
    #1;
    checkOutput({name, "_sticky"}, error, 1);
    checkOutput({name, "_sticky_type"}, errorType, expType);
  endtask

  initial begin
    $display("[TB] starting painterengine_gpu_dma_writer bench");

    buildBursts(32'h0000_13F8, 4);
    checkOutput("model_13f8_count", awAddrQ.size(), 2);
    checkOutput("model_13f8_addr0", awAddrQ[0], 32'h13F8);
    checkOutput("model_13f8_len0", awLenQ[0], 1);
    checkOutput("model_13f8_addr1", awAddrQ[1], 32'h1400);
    checkOutput("model_13f8_len1", awLenQ[1], 1);
    buildBursts(32'h0, 300);
    checkOutput("model_300_count", awAddrQ.size(), 2);
    checkOutput("model_300_len0", awLenQ[0], 255);
    checkOutput("model_300_addr1", awAddrQ[1], 32'h400);
    checkOutput("model_300_len1", awLenQ[1], 43);
    buildBursts(32'h1000, 4);
    checkOutput("model_1000_len0", awLenQ[0], 3);

    rst = 1'b1;
    dvalid = 4'hF;
    wReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_type", errorType, 0);
    checkIdleBus("rst");
    checkOutput("rst_awaddr", awAddr, 0);
    checkOutput("rst_awlen", awLen, 0);
    checkOutput("rst_wdata", wData, 0);
    checkOutput("rst_wlast", wLast, 0);
    checkOutput("const_awid", awId, 0);
    checkOutput("const_awsize", awSize, 3'b010);
    checkOutput("const_awburst", awBurst, 2'b01);
    checkOutput("const_wstrb", wStrb, 4'hF);
    checkOutput("const_awcache", awCache, 4'b0010);
    checkOutput("const_misc", {awLock, awProt, awQos}, 0);

    applyStimulus(0, 32'h0000_1000, 4, 2'b00, 0, 0);
    applyStimulus(0, 32'h0000_13F8, 4, 2'b00, 20, 0);
    applyStimulus(3, 32'h0000_0000, 300, 2'b00, 30, 0);
    for (int t = 0; t < 4; t++)
      applyStimulus($urandom_range(3), 32'h2000 + 32'(4 * $urandom_range(200, 255)),
                    $urandom_range(1, 70), 2'b00, $urandom_range(0, 40), 0);

    runError(4'b0011, 32'h1000, 32'd4, 0, 3'b001, "router");
    runError(4'b0001, 32'h1002, 32'd4, 0, 3'b010, "misaligned");
    runError(4'b0001, 32'h1000, 32'd0, 0, 3'b010, "zero_len");
    runError(4'b0001, 32'h1000, 32'd4, 1, 3'b011, "aw_timeout");
    runError(4'b0001, 32'h1000, 32'd4, 2, 3'b100, "w_timeout");
    runError(4'b0001, 32'h1000, 32'd4, 3, 3'b110, "b_timeout");
    applyStimulus(1, 32'h0000_3000, 6, 2'b10, 10, 0);

    applyStimulus(3, 32'h0000_0000, 300, 2'b00, 10, 40);
    @(negedge clk);
    rst = 1'b1; router = 4'b0000; dvalid = 4'hF;
    awReady = 1'b1; wReady = 1'b1; bValid = 1'b1;
    @(negedge clk);
    #1;
    checkIdleBus("midrst");
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_error", error, 0);
    checkOutput("midrst_wlast", wLast, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_routing_error", error, 1);
    checkOutput("midrst_routing_type", errorType, 3'b001);
    checkIdleBus("midrst_after");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
